// File: rtl/de_magn.sv
// rtl/de_magn.sv - JPEG magnitude decoder: rebuilds a signed coefficient from SSSS plus its appended bits.
module de_magn #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   ssss,
  input  logic         ssss_valid,
  output logic         ssss_ready,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic         bit_ready,
  output logic [W-1:0] magn,
  output logic         magn_valid,
  input  logic         magn_ready,
  output logic         err
);

  localparam logic [1:0]   IDLE  = 2'd0;
  localparam logic [1:0]   SHIFT = 2'd1;
  localparam logic [1:0]   OUT   = 2'd2;
  localparam logic [3:0]   WMAX  = 4'(W);
  localparam logic [W-1:0] ONE   = {{(W-1){1'b0}}, 1'b1};

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [3:0]   cat;
  logic [W-1:0] shreg;
  logic [W-1:0] vnext;
  logic [W-1:0] pow;
  logic [W-1:0] half;
  logic [W-1:0] dec;

  // Bits above cat are always zero because shreg is cleared on every new category.
  always_comb begin
    vnext = (shreg << 1) | {{(W-1){1'b0}}, bit_in};
    pow   = ONE << cat;
    half  = ONE << (cat - 4'd1);
    dec   = ((vnext & half) != '0) ? vnext : vnext + ONE - pow;
  end

  assign ssss_ready = (state == IDLE);
  assign bit_ready  = (state == SHIFT);
  assign magn_valid = (state == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cat   <= '0;
      shreg <= '0;
      magn  <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (ssss_valid) begin
            cat   <= ssss;
            cnt   <= ssss;
            shreg <= '0;
            if (ssss == 4'd0) begin
              magn  <= '0;
              state <= OUT;
            end else if (ssss > WMAX) begin
              magn  <= '0;
              err   <= 1'b1;
              state <= OUT;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            shreg <= vnext;
            cnt   <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              magn  <= dec;
              state <= OUT;
            end
          end
        end
        OUT: begin
          if (magn_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
